ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_WIDTH, 8, RAM word address width; top 2 bits select the bank and pass through untouched.
  DATA_WIDTH, 8, RAM data width.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, input, 1, single clock; all state updates on rising edge.
  rst, input, 1, synchronous active-high reset.
  req, input, 2, per-port access request; held high with fields stable until gnt.
  req_we, input, 2, per-port op select: 1 = write, 0 = read.
  req_addr, input, 2*ADDR_WIDTH, per-port address; port k occupies slice k.
  req_wdata, input, 2*DATA_WIDTH, per-port write data; port k occupies slice k.
  gnt, output, 2, one-cycle accept pulse per port.
  rdata, output, DATA_WIDTH, shared registered read data, valid with rvalid.
  rvalid, output, 2, one-cycle read-complete pulse per port.
  ram_addr, output, ADDR_WIDTH, RAM address.
  ram_data, inout, DATA_WIDTH, RAM bidirectional data bus.
  ram_cs, output, 1, RAM chip select.
  ram_we, output, 1, RAM write enable.
  ram_oe, output, 1, RAM output enable.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, WR, RD1, RD2.
REQ-005 IDLE, any req high at edge T: latch winner index, addr, op and wdata; enter WR or RD1 at T+1. No req: stay IDLE.
REQ-006 gnt[winner] SHALL be 1 for exactly the first cycle of WR or RD1, and 0 otherwise.
REQ-007 WR (1 cycle): ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with latched wdata; next state IDLE.
REQ-008 RD1: ram_cs=1, ram_we=0, ram_oe=1, ram_data hi-Z; next state RD2.
REQ-009 RD2: same controls as RD1; rdata captures ram_data at end of RD2; next state IDLE.
REQ-010 rvalid[winner] SHALL pulse for the cycle after RD2. Read latency: gnt at T+1, rvalid at T+3.
REQ-011 rdata SHALL hold its value until the next read capture.
REQ-012 IDLE outputs: ram_cs=0, ram_we=0, ram_oe=0, ram_data hi-Z. ram_addr holds its last latched value.
REQ-013 ram_data SHALL be driven only in WR; this guarantees bus turnaround with no contention.
REQ-014 Round-robin priority pointer:
  - On simultaneous requests, the port not granted last SHALL win.
  - After a grant to port k, the pointer SHALL favor port 1-k.
  - A lone requester wins regardless of the pointer.
REQ-015 Accesses are serialized. At least one IDLE cycle separates consecutive accesses.
  - Write throughput: one per 2 cycles.
  - Read throughput: one per 3 cycles.
REQ-016 A req arriving mid-access SHALL be evaluated only in the next IDLE cycle.
REQ-017 A req dropped before gnt SHALL be ignored with no side effects.
REQ-018 ram_addr SHALL equal the latched req_addr slice, with no bank decode or remapping.

Reset
REQ-019 When rst is high at an edge, the next cycle SHALL show:
  - state IDLE;
  - gnt=0, rvalid=0, rdata=0, ram_addr=0;
  - ram_cs/ram_we/ram_oe=0, ram_data hi-Z;
  - pointer favoring port 0.
REQ-020 Reset mid-access (WR, RD1 or RD2) SHALL abort the access with no rvalid. The requester must re-request.

Structure
REQ-021 Shared package ram_arb_pkg SHALL hold:
  - the state enum (IDLE, WR, RD1, RD2);
  - NUM_PORTS=2;
  - port-index typedef.
REQ-022 Sub-module rr_arbiter2 SHALL hold the 2-way round-robin pick and pointer update. The FSM, datapath latches and tristate driver stay in ram_arbiter.

Verification
REQ-023 Single write: port0 write addr 0x45, data 0xA5 -> gnt[0] at T+1; cs=we=1 and ram_data=0xA5 for 1 cycle.
REQ-024 Readback: port1 read addr 0x45 after REQ-023 write -> gnt[1] at T+1; rvalid[1] at T+3 with rdata=0xA5.
REQ-025 Contention: both ports request every cycle for 8 grants -> grants alternate 0,1,0,1...; port0 first after reset.
REQ-026 Cross-bank: writes to 0x03, 0x43, 0x83, 0xC3 with data 0x11, 0x22, 0x33, 0x44, then reads -> each returns its own data; ram_addr top bits match.
REQ-027 Reset in RD1 -> no rvalid; next cycle all RAM controls 0, bus hi-Z; a subsequent read completes normally.
REQ-028 Contention check: whenever ram_cs && ram_oe && !ram_we, the arbiter drives ram_data hi-Z.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, port count and port index.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef logic [0:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the pointer advances only when the FSM accepts the winner.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 accept_i,
    output logic                 win_vld_o,
    output port_idx_t            win_idx_o
);

    // prio_q names the port that wins a tie
    port_idx_t prio_q;
    port_idx_t prio_d;

    always_comb begin
        win_vld_o = |req_i;
        win_idx_o = prio_q;
        if (req_i == 2'b01) begin
            win_idx_o = 1'b0;
        end else if (req_i == 2'b10) begin
            win_idx_o = 1'b1;
        end
        prio_d = prio_q;
        if (accept_i && win_vld_o) begin
            prio_d = ~win_idx_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two request ports onto one async-style SRAM: 1-cycle writes, 2-cycle reads
// with registered read data; the data bus is driven only while writing.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    inout  wire  [DATA_WIDTH-1:0]           ram_data,
    output logic                            ram_cs,
    output logic                            ram_we,
    output logic                            ram_oe
);

    state_t                  state_q, state_d;
    port_idx_t               winner_q, winner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]    rvalid_q, rvalid_d;

    logic      arb_vld;
    port_idx_t arb_idx;
    logic      arb_accept;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .accept_i  (arb_accept),
        .win_vld_o (arb_vld),
        .win_idx_o (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = '0;
        arb_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    arb_accept = 1'b1;
                    winner_d   = arb_idx;
                    addr_d     = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d    = req_we[arb_idx] ? WR : RD1;
                end
            end
            WR:  state_d = IDLE;
            RD1: state_d = RD2;
            RD2: begin
                // RAM output has had two full cycles to settle by this edge
                rdata_d            = ram_data;
                rvalid_d[winner_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        gnt = '0;
        if ((state_q == WR) || (state_q == RD1)) begin
            gnt[winner_q] = 1'b1;
        end
    end

    assign ram_cs   = (state_q != IDLE);
    assign ram_we   = (state_q == WR);
    assign ram_oe   = (state_q == RD1) || (state_q == RD2);
    assign ram_addr = addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

    assign ram_data = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a transaction-level arbitration/memory model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  rdata, ram_addr;
    wire  [7:0]  ram_data;
    logic        ram_cs, ram_we, ram_oe;

    int checks = 0;
    int failures = 0;

    op_t        op_q0[$];
    op_t        op_q1[$];
    op_t        exp_gnt_q[$];
    logic [8:0] exp_rd_q[$];
    logic       gnt_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] last_rdata;
    logic       rand_en = 1'b0;
    int         n_rand = 0;
    logic [7:0] ram_mem [0:255];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_oe(ram_oe)
    );

    // Behavioural SRAM: drives the bus only while selected for read
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : 8'bz;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_op(logic p, logic we, logic [7:0] a, logic [7:0] d);
        op_t o;
        o.port = p; o.we = we; o.addr = a; o.wdata = d;
        return o;
    endfunction

    // SRAM write port
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_cs && ram_we) ram_mem[ram_addr] = ram_data;
        end
    end

    // Reference model: one access at a time, a tie goes to the port not served last
    initial begin
        logic [7:0] mdl_mem [0:255];
        int   busy;
        logic ptr;
        logic w;
        op_t  o;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        busy = 0;
        ptr  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                busy = 0;
                ptr  = 1'b0;
                exp_gnt_q.delete();
                exp_rd_q.delete();
            end else if (busy > 0) begin
                busy--;
            end else if (req != 2'b00) begin
                w = (req == 2'b11) ? ptr : req[1];
                o = mk_op(w, req_we[w], req_addr[int'(w)*8 +: 8], req_wdata[int'(w)*8 +: 8]);
                exp_gnt_q.push_back(o);
                ptr = ~w;
                if (o.we) begin
                    mdl_mem[o.addr] = o.wdata;
                    busy = 1;
                end else begin
                    exp_rd_q.push_back({w, mdl_mem[o.addr]});
                    busy = 2;
                end
            end
        end
    end

    // Monitor then requester driver, both on the falling edge
    initial begin
        op_t o;
        logic [8:0] r;
        logic have, dropped;
        req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        forever begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    o = exp_gnt_q.pop_front();
                    chk("gnt_vec", 32'(gnt), 32'(2'b01 << o.port));
                    chk("gnt_addr", 32'(ram_addr), 32'(o.addr));
                    chk("gnt_ctrl", 32'({ram_cs, ram_we, ram_oe}), 32'({1'b1, o.we, ~o.we}));
                    if (o.we) chk("wr_bus_data", 32'(ram_data), 32'(o.wdata));
                    gnt_log.push_back(o.port);
                end
            end
            if (rvalid != 2'b00) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    r = exp_rd_q.pop_front();
                    chk("rvalid_vec", 32'(rvalid), 32'(2'b01 << r[8]));
                    chk("rdata", 32'(rdata), 32'(r[7:0]));
                    rd_log.push_back(rdata);
                end
                last_rdata = rdata;
            end
            if (ram_cs && ram_oe && !ram_we) chk("rd_bus_no_contention", 32'(ram_data), 32'(ram_mem[ram_addr]));
            if (!ram_cs) chk("idle_ctrl_bus", 32'({ram_we, ram_oe, (ram_data == 8'h00) || $isunknown(ram_data)}), 32'b001);

            for (int k = 0; k < 2; k++) begin
                dropped = 1'b0;
                if (req[k] && gnt[k]) begin
                    req[k] = 1'b0;
                end else if (req[k] && rand_en && $urandom_range(0, 15) == 0) begin
                    req[k] = 1'b0;
                    dropped = 1'b1;
                end
                if (!req[k] && !dropped) begin
                    have = 1'b0;
                    if (k == 0 && op_q0.size() > 0) begin
                        o = op_q0.pop_front(); have = 1'b1;
                    end else if (k == 1 && op_q1.size() > 0) begin
                        o = op_q1.pop_front(); have = 1'b1;
                    end else if (rand_en && n_rand > 0 && $urandom_range(0, 1) == 1) begin
                        o = mk_op(k[0], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3)), 8'($urandom));
                        n_rand--;
                        have = 1'b1;
                    end
                    if (have) begin
                        req[k] = 1'b1;
                        req_we[k] = o.we;
                        req_addr[k*8 +: 8] = o.addr;
                        req_wdata[k*8 +: 8] = o.wdata;
                    end
                end
            end
        end
    end

    task automatic drain(string name);
        int n;
        n = 0;
        while ((op_q0.size() != 0 || op_q1.size() != 0 || req != 2'b00 || n_rand != 0 ||
                exp_gnt_q.size() != 0 || exp_rd_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s_timeout: outstanding work after %0d cycles, required 0", name, n);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(string name);
        chk({name, "_gnt_rvalid"}, 32'({gnt, rvalid}), 32'd0);
        chk({name, "_rdata"}, 32'(rdata), 32'd0);
        chk({name, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({name, "_ctrl"}, 32'({ram_cs, ram_we, ram_oe}), 32'd0);
    endtask

    initial begin
        logic [7:0] xb_addr [4];
        logic [7:0] xb_data [4];
        int n;
        xb_addr = '{8'h03, 8'h43, 8'h83, 8'hC3};
        xb_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_state("reset");
        rst = 1'b0;

        // Single write then readback from the other port
        op_q0.push_back(mk_op(1'b0, 1'b1, 8'h45, 8'hA5));
        drain("write45");
        op_q1.push_back(mk_op(1'b1, 1'b0, 8'h45, 8'h00));
        drain("read45");
        chk("readback_45", 32'(last_rdata), 32'hA5);

        // Contention after reset: pointer must restart favouring port 0
        op_q0.push_back(mk_op(1'b0, 1'b1, 8'h10, 8'h5A));
        drain("pre_contention");
        pulse_reset();
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            op_q0.push_back(mk_op(1'b0, 1'b1, 8'($urandom), 8'($urandom)));
            op_q1.push_back(mk_op(1'b1, 1'b1, 8'($urandom), 8'($urandom)));
        end
        drain("contention");
        chk("contention_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("contention_order", 32'(gnt_log[i]), 32'(i % 2));

        // Cross-bank writes then reads
        for (int i = 0; i < 4; i++) op_q0.push_back(mk_op(1'b0, 1'b1, xb_addr[i], xb_data[i]));
        drain("xbank_wr");
        rd_log.delete();
        for (int i = 0; i < 4; i++) op_q1.push_back(mk_op(1'b1, 1'b0, xb_addr[i], 8'h00));
        drain("xbank_rd");
        chk("xbank_count", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("xbank_data", 32'(rd_log[i]), 32'(xb_data[i]));

        // Reset while in RD1 aborts the read
        op_q0.push_back(mk_op(1'b0, 1'b0, 8'h83, 8'h00));
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(gnt[0] && ram_oe) && n < 50);
        chk("rd1_reached", 32'(gnt[0] && ram_oe), 32'd1);
        pulse_reset();
        chk_reset_state("rd1_reset");
        repeat (5) @(posedge clk);
        #2;
        op_q1.push_back(mk_op(1'b1, 1'b0, 8'h83, 8'h00));
        drain("after_reset_rd");
        chk("after_reset_rdata", 32'(last_rdata), 32'h33);

        // Randomised traffic with occasional withdrawn requests
        n_rand = 300;
        rand_en = 1'b1;
        n = 0;
        while (n_rand > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #2;
        rand_en = 1'b0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
